// File: rtl/calc_entry_ctrl.sv
// Keypad sequencer for the calculator: two-digit operand entry into RF[0]/RF[1],
// operator capture and a go/done ALU handshake bounded by ALU_TIMEOUT cycles.
module calc_entry_ctrl #(
  parameter int ALU_TIMEOUT = 15
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       alu_done,
  output logic [3:0] Din,
  output logic       level,
  output logic       W1,
  output logic       WE,
  output logic [1:0] op,
  output logic       alu_go,
  output logic       result_valid,
  output logic       err,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_A10  = 4'd0,
    S_A1   = 4'd1,
    S_AWR  = 4'd2,
    S_OP   = 4'd3,
    S_B10  = 4'd4,
    S_B1   = 4'd5,
    S_BWR  = 4'd6,
    S_EQ   = 4'd7,
    S_EXEC = 4'd8,
    S_SHOW = 4'd9
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(ALU_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [3:0] din_q, din_d;
  logic       level_q, level_d;
  logic       w1_q, w1_d;
  logic       we_q, we_d;
  logic [1:0] op_q, op_d;
  logic       go_q, go_d;
  logic       rv_q, rv_d;
  logic       err_q, err_d;
  logic [7:0] cnt_q, cnt_d;

  logic is_digit, is_op, is_eq, is_clr, key_ok;

  assign is_digit = (key_code <= 4'd9);
  assign is_op    = (key_code >= 4'hA) && (key_code <= 4'hC);
  assign is_eq    = (key_code == 4'hE);
  assign is_clr   = (key_code == 4'hF);

  always_comb begin
    state_d = state_q;
    din_d   = din_q;
    level_d = level_q;
    w1_d    = w1_q;
    op_d    = op_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    key_ok  = 1'b0;

    case (state_q)
      S_A10, S_SHOW: begin
        if (key_valid && is_digit) begin
          key_ok  = 1'b1;
          din_d   = key_code;
          level_d = 1'b1;
          w1_d    = 1'b0;
          state_d = S_A1;
          // A fresh calculation out of S_SHOW drops the previous error
          if (state_q == S_SHOW) err_d = 1'b0;
        end
      end
      S_A1, S_B1: begin
        if (key_valid && is_digit) begin
          key_ok  = 1'b1;
          din_d   = key_code;
          level_d = 1'b0;
          state_d = (state_q == S_A1) ? S_AWR : S_BWR;
        end
      end
      S_AWR: begin
        key_ok  = 1'b1;
        state_d = S_OP;
      end
      S_OP: begin
        if (key_valid && is_op) begin
          key_ok  = 1'b1;
          op_d    = key_code[1:0] + 2'd2;
          state_d = S_B10;
        end
      end
      S_B10: begin
        if (key_valid && is_digit) begin
          key_ok  = 1'b1;
          din_d   = key_code;
          level_d = 1'b1;
          w1_d    = 1'b1;
          state_d = S_B1;
        end
      end
      S_BWR: begin
        key_ok  = 1'b1;
        state_d = S_EQ;
      end
      S_EQ: begin
        if (key_valid && is_eq) begin
          key_ok  = 1'b1;
          cnt_d   = 8'd0;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (alu_done) begin
          cnt_d   = 8'd0;
          state_d = S_SHOW;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = 8'd0;
          err_d   = 1'b1;
          state_d = S_SHOW;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        key_ok  = 1'b1;
        state_d = S_A10;
      end
    endcase

    if (key_valid && !is_clr && !key_ok) err_d = 1'b1;

    // Clear wins over everything, including an in-flight ALU request
    if (key_valid && is_clr) begin
      state_d = S_A10;
      err_d   = 1'b0;
      cnt_d   = 8'd0;
    end

    we_d = (state_d == S_AWR) || (state_d == S_BWR);
    go_d = (state_d == S_EXEC);
    rv_d = (state_d == S_SHOW);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_A10;
      din_q   <= 4'd0;
      level_q <= 1'b1;
      w1_q    <= 1'b0;
      we_q    <= 1'b0;
      op_q    <= 2'd0;
      go_q    <= 1'b0;
      rv_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      din_q   <= din_d;
      level_q <= level_d;
      w1_q    <= w1_d;
      we_q    <= we_d;
      op_q    <= op_d;
      go_q    <= go_d;
      rv_q    <= rv_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Din          = din_q;
  assign level        = level_q;
  assign W1           = w1_q;
  assign WE           = we_q;
  assign op           = op_q;
  assign alu_go       = go_q;
  assign result_valid = rv_q;
  assign err          = err_q;
  assign state        = state_q;

endmodule

// File: doc/calc_entry_ctrl.md
# calc_entry_ctrl

Sequencing controller for the calculator's operand register file. It decodes single-cycle keypad events into two-digit operand entry. It drives the register file's `Din`/`level`/`W1`/`WE` controls so that operand A lands in RF[0] and operand B lands in RF[1]. It captures the operator key and runs a go/done handshake with the ALU, with a timeout. It sits between the keypad debouncer/decoder and the register file/ALU pair.

## Interface
- `ALU_TIMEOUT`, 15, max cycles `alu_go` may stay high waiting for `alu_done` (1..255)
- `CLK`  in  1  system clock; all state changes on rising edge
- `RST_N`  in  1  asynchronous, active-low reset
- `key_valid`  in  1  one-cycle pulse: `key_code` is valid this cycle
- `key_code`  in  4  0–9 digit; A add; B sub; C mul; D reserved; E equals; F clear
- `alu_done`  in  1  ALU result ready; sampled only in S_EXEC
- `Din`  out  4  digit to register file; registered, held until next accepted digit
- `level`  out  1  1 = tens digit on `Din`, 0 = ones digit
- `W1`  out  1  register-file write target: 0 = A, 1 = B
- `WE`  out  1  one-cycle register-file write strobe
- `op`  out  2  00 add, 01 sub, 10 mul; held from operator key until next operator key or clear
- `alu_go`  out  1  request to ALU; high for the whole of S_EXEC
- `result_valid`  out  1  high in S_SHOW
- `err`  out  1  sticky error flag
- `state`  out  4  current state encoding, for debug/display

## Operation
- States and encodings: S_A10=0, S_A1=1, S_AWR=2, S_OP=3, S_B10=4, S_B1=5, S_BWR=6, S_EQ=7, S_EXEC=8, S_SHOW=9. No other encodings are reachable; any illegal value goes to S_A10.
- S_A10, digit d → `Din`=d, `level`=1, next S_A1.
- S_A1, digit d → `Din`=d, `level`=0, next S_AWR.
- S_AWR → `WE`=1 with `W1`=0 for exactly one cycle, next S_OP. This is unconditional; keys arriving in this cycle are ignored.
- S_OP, key A/B/C → latch `op`, next S_B10.
- S_B10, S_B1 and S_BWR mirror S_A10, S_A1 and S_AWR, with `W1`=1 in S_BWR. S_BWR goes to S_EQ.
- S_EQ, key E → S_EXEC.
- S_EXEC: `alu_go`=1 and the timeout counter increments each cycle.
  - `alu_done`=1 → S_SHOW, counter cleared.
  - Counter reaches `ALU_TIMEOUT` with no `alu_done` → `err`=1, S_SHOW.
- S_SHOW: `result_valid`=1.
  - Digit d → starts a new calculation as in S_A10: `Din`=d, `level`=1, `err` cleared, next S_A1.
  - Key F → S_A10.
- Key F in any state → S_A10, `err`=0, `WE`=0, `alu_go`=0, timeout counter cleared. `op` and `Din` are unchanged. A clear in S_EXEC aborts the ALU request.
- Any other key not accepted in the current state (digit in S_OP/S_EQ, operator/E in a digit state, D anywhere, any non-F key in S_EXEC) is ignored and sets `err`=1. State does not change.
- `err` is cleared only by key F, reset, or the first digit of a new calculation from S_SHOW.
- Operands are always two digits (00–99); "7" is entered as 0,7.

## Timing
- Reset (asynchronous, `RST_N`=0) values:
  - state=S_A10, `Din`=0, `level`=1, `W1`=0, `WE`=0
  - `op`=00, `alu_go`=0, `result_valid`=0, `err`=0, counter=0
- All outputs are registered. A key accepted at edge k takes effect on the outputs after edge k.
- `WE` rises the cycle after the ones digit is accepted. `Din`/`level`/`W1` are stable for at least one cycle before and during `WE`.
- The register file presents `Dout_2` one edge after the S_BWR write. The earliest E key is accepted at the edge after S_EQ is entered, so `alu_go` never precedes valid operands.
- `alu_go` is high from the cycle after E is accepted until the edge at which `alu_done` or the timeout is seen. It is never high for more than `ALU_TIMEOUT` cycles.
- Reset mid-operation aborts everything immediately. No partial `WE` pulse survives reset.

## Test plan
- Keys 1,2,A,0,5,E with `alu_done` 3 cycles after `alu_go` → each write is a single-cycle `WE`:
  - `WE` with `W1`=0 after the second digit; the register file holds 12 in RF[0].
  - `WE` with `W1`=1 later; RF[1]=05.
  - `op`=00, `alu_go` high for 3 cycles, then `result_valid`=1 and `state`=9.
- Keys 9,9,C,9,9,E with `alu_done` never asserted → `alu_go` high for exactly 15 cycles, then `err`=1 and S_SHOW.
- Key A in S_A10, then key 5 in S_OP → `err`=1 and no state change for each; the following F → `err`=0 and `state`=0.
- Keys 3,4,B,F → S_A10, no second `WE`, `op` stays 01.
- `RST_N` pulsed low in S_EXEC with `alu_go`=1 → all outputs at their reset values asynchronously.
- From S_SHOW, key 7 → `err` cleared, `level`=1, `Din`=7, `state`=1.
